// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch unit: redirect sources and parameter defaults.
package pc_pkg;

  typedef enum logic [2:0] {
    REDIR_SEQ,
    REDIR_TRAP,
    REDIR_JAL,
    REDIR_JALR,
    REDIR_BRANCH
  } redir_e;

  localparam int          XLEN_DEF        = 16;
  localparam int unsigned RESET_VEC_DEF   = 0;
  localparam int          INSTR_BYTES_DEF = 4;
  localparam int          RAS_DEPTH_DEF   = 4;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control/status bundle between the pipeline control (master) and the fetch unit (slave).
interface pc_fetch_unit_if #(
  parameter int XLEN = 16
) ();

  logic            stall_i;
  logic            trap_en_i;
  logic [XLEN-1:0] trap_vec_i;
  logic            jal_en_i;
  logic            branch_en_i;
  logic [XLEN-1:0] imm_i;
  logic            jalr_en_i;
  logic [XLEN-1:0] alu_data_i;
  logic            call_i;
  logic            ret_i;

  logic [XLEN-1:0] pc_o;
  logic            pc_valid_o;
  logic [XLEN-1:0] ras_top_o;
  logic            ras_valid_o;
  logic            ras_hit_o;
  logic            ras_underflow_o;
  logic            misalign_o;

  modport master (
    output stall_i, trap_en_i, trap_vec_i, jal_en_i, branch_en_i, imm_i,
           jalr_en_i, alu_data_i, call_i, ret_i,
    input  pc_o, pc_valid_o, ras_top_o, ras_valid_o, ras_hit_o,
           ras_underflow_o, misalign_o
  );

  modport slave (
    input  stall_i, trap_en_i, trap_vec_i, jal_en_i, branch_en_i, imm_i,
           jalr_en_i, alu_data_i, call_i, ret_i,
    output pc_o, pc_valid_o, ras_top_o, ras_valid_o, ras_hit_o,
           ras_underflow_o, misalign_o
  );

endinterface

// File: rtl/pc_fetch_unit_return_stack.sv
// Circular return-address stack: push/pop/replace/flush; a push when full overwrites the oldest entry.
module return_stack #(
  parameter int XLEN  = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [XLEN-1:0]            din,
  output logic [XLEN-1:0]            top,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   top_idx;
  logic [CW-1:0]   cnt;
  logic            nonempty;
  logic            replace;

  assign top_idx  = ptr - 1'b1;
  assign nonempty = (cnt != '0);
  // push+pop on a non-empty stack rewrites the top slot instead of moving the pointer
  assign replace  = push && pop && nonempty;
  assign top      = nonempty ? mem[top_idx] : '0;
  assign count    = cnt;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push && !replace) begin
      ptr <= ptr + 1'b1;
      if (cnt != CW'(DEPTH)) cnt <= cnt + 1'b1;
    end else if (pop && !push && nonempty) begin
      ptr <= ptr - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end

  // Entry storage; contents are don't-care while the stack is empty, so no reset
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      if (replace) mem[top_idx] <= din;
      else         mem[ptr]     <= din;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter with prioritized redirects, alignment rejection and a return-address stack.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int          XLEN        = XLEN_DEF,
  parameter int unsigned RESET_VEC   = RESET_VEC_DEF,
  parameter int          INSTR_BYTES = INSTR_BYTES_DEF,
  parameter int          RAS_DEPTH   = RAS_DEPTH_DEF
) (
  input logic             clk,
  input logic             rst,
  pc_fetch_unit_if.slave  bus
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
  localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);

  redir_e                    redir;
  logic [XLEN-1:0]           pc_q, pc_d, target, link, jalr_tgt;
  logic                      valid_q;
  logic                      mis_q, mis_d, uf_q, uf_d, hit_q, hit_d;
  logic                      misaligned, ras_ok;
  logic                      ras_push, ras_pop, ras_flush;
  logic [XLEN-1:0]           ras_top;
  logic [$clog2(RAS_DEPTH):0] ras_cnt;

  assign link     = pc_q + STEP;
  assign jalr_tgt = bus.alu_data_i & ~XLEN'(1);

  // Next-PC selection: trap > jal > jalr > branch > sequential
  always_comb begin
    redir = REDIR_SEQ;
    if      (bus.trap_en_i)   redir = REDIR_TRAP;
    else if (bus.jal_en_i)    redir = REDIR_JAL;
    else if (bus.jalr_en_i)   redir = REDIR_JALR;
    else if (bus.branch_en_i) redir = REDIR_BRANCH;

    case (redir)
      REDIR_TRAP:               target = bus.trap_vec_i;
      REDIR_JAL, REDIR_BRANCH:  target = pc_q + bus.imm_i;
      REDIR_JALR:               target = jalr_tgt;
      default:                  target = link;
    endcase

    // traps load unconditionally; other redirects must land on an instruction boundary
    misaligned = (redir != REDIR_SEQ) && (redir != REDIR_TRAP) && ((target & ALIGN_MASK) != '0);
    ras_ok     = !bus.stall_i && !bus.trap_en_i && !misaligned;

    pc_d = pc_q;
    if (bus.trap_en_i || (!bus.stall_i && !misaligned)) pc_d = target;

    ras_flush = bus.trap_en_i;
    ras_push  = bus.call_i && ras_ok;
    ras_pop   = bus.ret_i && ras_ok;

    mis_d = misaligned && !bus.stall_i && !bus.trap_en_i;
    uf_d  = bus.ret_i && !bus.call_i && ras_ok && (ras_cnt == '0);
    hit_d = bus.ret_i && bus.jalr_en_i && !bus.stall_i && !bus.trap_en_i &&
            (ras_cnt != '0) && (ras_top == jalr_tgt);
  end

  // PC, valid flag and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= XLEN'(RESET_VEC);
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      uf_q    <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      mis_q   <= mis_d;
      uf_q    <= uf_d;
      hit_q   <= hit_d;
    end
  end

  return_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .flush (ras_flush),
    .din   (link),
    .top   (ras_top),
    .count (ras_cnt)
  );

  assign bus.pc_o            = pc_q;
  assign bus.pc_valid_o      = valid_q;
  assign bus.ras_top_o       = ras_top;
  assign bus.ras_valid_o     = (ras_cnt != '0);
  assign bus.ras_hit_o       = hit_q;
  assign bus.ras_underflow_o = uf_q;
  assign bus.misalign_o      = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: driver queues expected post-edge state, monitor checks on negedge.
module tb_pc_fetch_unit;

  typedef struct {
    string       name;
    int          due;
    logic [15:0] pc;
    logic        v, mis, uf, hit, rv;
    logic [15:0] top;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  pc_fetch_unit_if #(.XLEN(16)) bus ();

  pc_fetch_unit #(
    .XLEN(16), .RESET_VEC(0), .INSTR_BYTES(4), .RAS_DEPTH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic clr();
    bus.stall_i = 0; bus.trap_en_i = 0; bus.trap_vec_i = '0;
    bus.jal_en_i = 0; bus.branch_en_i = 0; bus.imm_i = '0;
    bus.jalr_en_i = 0; bus.alu_data_i = '0; bus.call_i = 0; bus.ret_i = 0;
  endtask

  // queue the state expected after the next edge, take the edge, clear the inputs
  task automatic expect_next(input string name, input logic [15:0] pc, input logic v,
                             input logic mis, input logic uf, input logic hit,
                             input logic [15:0] top, input logic rv);
    exp_t e;
    e.name = name; e.due = cyc + 1; e.pc = pc; e.v = v; e.mis = mis;
    e.uf = uf; e.hit = hit; e.top = top; e.rv = rv;
    q.push_back(e);
    @(posedge clk); #1;
    clr();
  endtask

  task automatic chk(input string name, input string fld, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%04h expected 0x%04h", name, fld, act, exp);
    end
  endtask

  // Monitor: compare every queued expectation that falls due this cycle
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.due != cyc) begin
        checks++; errors++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.due, cyc);
      end else begin
        chk(e.name, "pc",        bus.pc_o,                    e.pc);
        chk(e.name, "valid",     {15'd0, bus.pc_valid_o},     {15'd0, e.v});
        chk(e.name, "misalign",  {15'd0, bus.misalign_o},     {15'd0, e.mis});
        chk(e.name, "underflow", {15'd0, bus.ras_underflow_o},{15'd0, e.uf});
        chk(e.name, "hit",       {15'd0, bus.ras_hit_o},      {15'd0, e.hit});
        chk(e.name, "ras_top",   bus.ras_top_o,               e.top);
        chk(e.name, "ras_valid", {15'd0, bus.ras_valid_o},    {15'd0, e.rv});
      end
    end
  end

  initial begin
    clr();
    rst = 1;
    @(posedge clk); #1;

    // reset and sequential fetch
    rst = 1; expect_next("reset", 16'h0000, 0, 0, 0, 0, 16'h0000, 0);
    rst = 0;
    expect_next("seq4",  16'h0004, 1, 0, 0, 0, 16'h0000, 0);
    expect_next("seq8",  16'h0008, 1, 0, 0, 0, 16'h0000, 0);
    expect_next("seq12", 16'h000C, 1, 0, 0, 0, 16'h0000, 0);
    expect_next("seq16", 16'h0010, 1, 0, 0, 0, 16'h0000, 0);

    // priority and alignment
    bus.jal_en_i = 1; bus.branch_en_i = 1; bus.jalr_en_i = 1;
    bus.imm_i = 16'h0020; bus.alu_data_i = 16'h0101;
    expect_next("prio_jal", 16'h0030, 1, 0, 0, 0, 16'h0000, 0);
    bus.jalr_en_i = 1; bus.alu_data_i = 16'h0101;
    expect_next("jalr", 16'h0100, 1, 0, 0, 0, 16'h0000, 0);
    bus.jal_en_i = 1; bus.imm_i = 16'h0002;
    expect_next("jal_misalign", 16'h0100, 1, 1, 0, 0, 16'h0000, 0);
    expect_next("misalign_clr", 16'h0104, 1, 0, 0, 0, 16'h0000, 0);

    // wrap, stall, trap through stall flushing the stack
    bus.trap_en_i = 1; bus.trap_vec_i = 16'hFFFC;
    expect_next("trap_fffc", 16'hFFFC, 1, 0, 0, 0, 16'h0000, 0);
    expect_next("wrap", 16'h0000, 1, 0, 0, 0, 16'h0000, 0);
    bus.call_i = 1;
    expect_next("call_at0", 16'h0004, 1, 0, 0, 0, 16'h0004, 1);
    bus.stall_i = 1; bus.call_i = 1;
    expect_next("stall_call", 16'h0004, 1, 0, 0, 0, 16'h0004, 1);
    bus.stall_i = 1; bus.jal_en_i = 1; bus.imm_i = 16'h0008;
    expect_next("stall_jal", 16'h0004, 1, 0, 0, 0, 16'h0004, 1);
    bus.trap_en_i = 1; bus.stall_i = 1; bus.trap_vec_i = 16'h0200; bus.call_i = 1;
    expect_next("trap_stall", 16'h0200, 1, 0, 0, 0, 16'h0000, 0);

    // depth-4 stack: 5 calls, 5 returns
    rst = 1; expect_next("reset2", 16'h0000, 0, 0, 0, 0, 16'h0000, 0);
    rst = 0;
    bus.call_i = 1; expect_next("call1", 16'h0004, 1, 0, 0, 0, 16'h0004, 1);
    bus.call_i = 1; expect_next("call2", 16'h0008, 1, 0, 0, 0, 16'h0008, 1);
    bus.call_i = 1; expect_next("call3", 16'h000C, 1, 0, 0, 0, 16'h000C, 1);
    bus.call_i = 1; expect_next("call4", 16'h0010, 1, 0, 0, 0, 16'h0010, 1);
    bus.call_i = 1; expect_next("call5", 16'h0014, 1, 0, 0, 0, 16'h0014, 1);
    bus.ret_i = 1;  expect_next("ret1",  16'h0018, 1, 0, 0, 0, 16'h0010, 1);
    bus.ret_i = 1;  expect_next("ret2",  16'h001C, 1, 0, 0, 0, 16'h000C, 1);
    bus.ret_i = 1;  expect_next("ret3",  16'h0020, 1, 0, 0, 0, 16'h0008, 1);
    bus.ret_i = 1;  expect_next("ret4",  16'h0024, 1, 0, 0, 0, 16'h0000, 0);
    bus.ret_i = 1;  expect_next("ret5_uf", 16'h0028, 1, 0, 1, 0, 16'h0000, 0);
    expect_next("uf_clr", 16'h002C, 1, 0, 0, 0, 16'h0000, 0);

    // return prediction hit / miss
    bus.jal_en_i = 1; bus.imm_i = 16'h0014;
    expect_next("jal_to40", 16'h0040, 1, 0, 0, 0, 16'h0000, 0);
    bus.call_i = 1; expect_next("call_40", 16'h0044, 1, 0, 0, 0, 16'h0044, 1);
    bus.ret_i = 1; bus.jalr_en_i = 1; bus.alu_data_i = 16'h0044;
    expect_next("ret_hit", 16'h0044, 1, 0, 0, 1, 16'h0000, 0);
    bus.jalr_en_i = 1; bus.alu_data_i = 16'h0040;
    expect_next("back_to40", 16'h0040, 1, 0, 0, 0, 16'h0000, 0);
    bus.call_i = 1; expect_next("call_40b", 16'h0044, 1, 0, 0, 0, 16'h0044, 1);
    bus.ret_i = 1; bus.jalr_en_i = 1; bus.alu_data_i = 16'h0048;
    expect_next("ret_miss", 16'h0048, 1, 0, 0, 0, 16'h0000, 0);

    // simultaneous call+ret replaces top
    bus.call_i = 1; expect_next("call_48", 16'h004C, 1, 0, 0, 0, 16'h004C, 1);
    bus.call_i = 1; expect_next("call_4c", 16'h0050, 1, 0, 0, 0, 16'h0050, 1);
    bus.call_i = 1; bus.ret_i = 1;
    expect_next("replace", 16'h0054, 1, 0, 0, 0, 16'h0054, 1);
    bus.ret_i = 1; expect_next("pop_after_rep", 16'h0058, 1, 0, 0, 0, 16'h004C, 1);
    bus.ret_i = 1; expect_next("pop_last", 16'h005C, 1, 0, 0, 0, 16'h0000, 0);
    bus.ret_i = 1; expect_next("pop_empty", 16'h0060, 1, 0, 1, 0, 16'h0000, 0);
    bus.call_i = 1; bus.ret_i = 1;
    expect_next("replace_empty", 16'h0064, 1, 0, 0, 0, 16'h0064, 1);

    // misaligned jalr leaves PC and stack alone
    bus.jalr_en_i = 1; bus.alu_data_i = 16'h0103; bus.call_i = 1;
    expect_next("jalr_misalign", 16'h0064, 1, 1, 0, 0, 16'h0064, 1);
    expect_next("after_mis", 16'h0068, 1, 0, 0, 0, 16'h0064, 1);

    // reset dominates trap; branch wrap; unaligned trap accepted over jal
    rst = 1; bus.trap_en_i = 1; bus.trap_vec_i = 16'h0300;
    expect_next("reset_vs_trap", 16'h0000, 0, 0, 0, 0, 16'h0000, 0);
    rst = 0;
    expect_next("post_reset", 16'h0004, 1, 0, 0, 0, 16'h0000, 0);
    bus.branch_en_i = 1; bus.imm_i = 16'hFFF8;
    expect_next("branch_neg", 16'hFFFC, 1, 0, 0, 0, 16'h0000, 0);
    expect_next("wrap2", 16'h0000, 1, 0, 0, 0, 16'h0000, 0);
    bus.trap_en_i = 1; bus.trap_vec_i = 16'h0123; bus.jal_en_i = 1; bus.imm_i = 16'h0004;
    expect_next("trap_unaligned", 16'h0123, 1, 0, 0, 0, 16'h0000, 0);
    expect_next("seq_after_trap", 16'h0127, 1, 0, 0, 0, 16'h0000, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
